// File: rtl/laser_host_pkg.sv
// Shared definitions for the LASER host driver/checker.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: FSM state encoding, frame size, coverage radius, coordinate and
// index widths, point record, squared-distance helper.
package laser_host_pkg;

  localparam int N_OBJ     = 40;   // points per frame
  localparam int RADIUS_SQ = 16;   // inclusive squared coverage radius
  localparam int CW        = 4;    // coordinate width
  localparam int IW        = 6;    // point index width

  typedef logic [CW-1:0] coord_t;
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RSTE   = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    CHECK  = 3'd4,
    REPORT = 3'd5
  } state_t;

  // Squared Euclidean distance between two points. Each absolute difference
  // is 4 bits, each square 8 bits, and the sum needs a 9th bit (15^2+15^2=450).
  function automatic logic [8:0] dist_sq(input coord_t ax, input coord_t ay,
                                         input coord_t bx, input coord_t by);
    coord_t     dx;
    coord_t     dy;
    logic [7:0] sx;
    logic [7:0] sy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    sx = {4'b0000, dx} * {4'b0000, dx};
    sy = {4'b0000, dy} * {4'b0000, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Coverage test of one point against two circle centres.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: px/py point, c1x/c1y and c2x/c2y centres, hit = inside C1 or C2
// (inclusive radius).
module laser_cover_chk
  import laser_host_pkg::*;
#(
  parameter int RADIUS = RADIUS_SQ
) (
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] c1x,
  input  logic [CW-1:0] c1y,
  input  logic [CW-1:0] c2x,
  input  logic [CW-1:0] c2y,
  output logic          hit
);

  localparam logic [8:0] R9 = 9'(RADIUS);

  logic in_c1;
  logic in_c2;

  assign in_c1 = (dist_sq(px, py, c1x, c1y) <= R9);
  assign in_c2 = (dist_sq(px, py, c2x, c2y) <= R9);

  // A point inside both circles still produces a single hit.
  assign hit = in_c1 | in_c2;

endmodule

// File: rtl/laser_host.sv
// Host driver/checker for the LASER engine: load points, reset engine, stream
// points, capture centres on DONE, then score coverage over the frame.
// Latency: START->RES_VALID = 2 + N_OBJ + engine time + 1 + N_OBJ + 1 cycles.
// Backpressure: none; WR_EN and START are ignored while BUSY.
// Ports: WR_* point loader, START/BUSY control, ENG_* engine stream and
// results, RES_* captured centres, covered count and timeout flag.
module laser_host
  import laser_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1048575
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [IW-1:0] WR_ADDR,
  input  logic [CW-1:0] WR_X,
  input  logic [CW-1:0] WR_Y,
  input  logic          START,
  output logic          BUSY,
  output logic          ENG_RST,
  output logic [CW-1:0] ENG_X,
  output logic [CW-1:0] ENG_Y,
  input  logic [CW-1:0] ENG_C1X,
  input  logic [CW-1:0] ENG_C1Y,
  input  logic [CW-1:0] ENG_C2X,
  input  logic [CW-1:0] ENG_C2Y,
  input  logic          ENG_DONE,
  output logic          RES_VALID,
  output logic [CW-1:0] RES_C1X,
  output logic [CW-1:0] RES_C1Y,
  output logic [CW-1:0] RES_C2X,
  output logic [CW-1:0] RES_C2Y,
  output logic [IW-1:0] RES_COUNT,
  output logic          RES_TIMEOUT
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t          state;
  state_t          state_nxt;
  point_t          mem [N_OBJ];
  idx_t            idx;        // stream index in STREAM, check index in CHECK
  idx_t            rd_addr;
  point_t          rd_pt;
  logic [TW-1:0]   tcnt;
  idx_t            acc;
  logic            hit;
  logic            last_idx;
  logic            t_expired;
  logic            wr_ok;

  logic            eng_rst;
  point_t          eng_pt;
  coord_t          res_c1x;
  coord_t          res_c1y;
  coord_t          res_c2x;
  coord_t          res_c2y;
  idx_t            res_count;
  logic            res_timeout;

  assign last_idx  = (idx == IW'(N_OBJ - 1));
  assign t_expired = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign wr_ok     = WR_EN && (state == IDLE) && (WR_ADDR < IW'(N_OBJ));

  // Point memory: no reset, frozen outside IDLE.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[WR_ADDR] <= {WR_X, WR_Y};
    end
  end

  // STREAM pre-fetches the next point so ENG_X/ENG_Y are registered and show
  // point[k] during the k-th STREAM cycle; CHECK reads the current index.
  always_comb begin
    rd_addr = idx;
    if (state == RSTE) begin
      rd_addr = '0;
    end else if (state == STREAM) begin
      rd_addr = idx + 1'b1;
    end
  end

  assign rd_pt = (rd_addr < IW'(N_OBJ)) ? mem[rd_addr] : '0;

  laser_cover_chk #(
    .RADIUS(RADIUS_SQ)
  ) u_chk (
    .px  (rd_pt.x),
    .py  (rd_pt.y),
    .c1x (res_c1x),
    .c1y (res_c1y),
    .c2x (res_c2x),
    .c2y (res_c2y),
    .hit (hit)
  );

  // Next-state logic. DONE outside WAIT is ignored; DONE wins over expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RSTE;
      RSTE:    state_nxt = STREAM;
      STREAM:  if (last_idx) state_nxt = WAIT;
      WAIT: begin
        if (ENG_DONE) begin
          state_nxt = CHECK;
        end else if (t_expired) begin
          state_nxt = REPORT;
        end
      end
      CHECK:   if (last_idx) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      eng_rst     <= 1'b1;
      eng_pt      <= '0;
      idx         <= '0;
      tcnt        <= '0;
      acc         <= '0;
      res_c1x     <= '0;
      res_c1y     <= '0;
      res_c2x     <= '0;
      res_c2y     <= '0;
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Engine held in reset in IDLE and RSTE only.
      eng_rst <= (state_nxt == IDLE) || (state_nxt == RSTE);
      case (state)
        RSTE: begin
          idx    <= '0;
          eng_pt <= rd_pt;
        end
        STREAM: begin
          if (!last_idx) begin
            idx    <= idx + 1'b1;
            eng_pt <= rd_pt;
          end else begin
            tcnt <= '0;   // ENG_X/ENG_Y keep the last point
          end
        end
        WAIT: begin
          if (ENG_DONE) begin
            res_c1x     <= ENG_C1X;
            res_c1y     <= ENG_C1Y;
            res_c2x     <= ENG_C2X;
            res_c2y     <= ENG_C2Y;
            res_timeout <= 1'b0;
            idx         <= '0;
            acc         <= '0;
          end else if (t_expired) begin
            res_c1x     <= '0;
            res_c1y     <= '0;
            res_c2x     <= '0;
            res_c2y     <= '0;
            res_count   <= '0;
            res_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          acc <= acc + {{(IW-1){1'b0}}, hit};
          idx <= idx + 1'b1;
          if (last_idx) begin
            res_count <= acc + {{(IW-1){1'b0}}, hit};
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY        = (state != IDLE);
  assign RES_VALID   = (state == REPORT);
  assign ENG_RST     = eng_rst;
  assign ENG_X       = eng_pt.x;
  assign ENG_Y       = eng_pt.y;
  assign RES_C1X     = res_c1x;
  assign RES_C1Y     = res_c1y;
  assign RES_C2X     = res_c2x;
  assign RES_C2Y     = res_c2y;
  assign RES_COUNT   = res_count;
  assign RES_TIMEOUT = res_timeout;

endmodule
